// File: rtl/ysyx_23060025_ifu_prefetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
// Holds the fetch FSM state encoding and the default reset PC.
package ysyx_23060025_ifu_prefetch_pkg;

    typedef enum logic [1:0] {
        IFU_ST_FETCH     = 2'b00,
        IFU_ST_DRAIN     = 2'b01,
        IFU_ST_HALT_PEND = 2'b11,
        IFU_ST_HALT      = 2'b10
    } ifu_state_e;

    localparam logic [31:0] PC_RESET_VAL = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060025_fetch_fifo.sv
// Circular prefetch buffer with registered head and occupancy count.
// Ports: push/data_i in, pop in, flush in, head_o/count_o out; sync active-low reset.
module ysyx_23060025_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rstn_i && !flush_i && push_i) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Empty buffer presents zeros so the IDU never sees stale entries.
    assign head_o  = (count_q != '0) ? mem_q[rptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ysyx_23060025_ifu_prefetch.sv
// Instruction fetch unit with prefetch buffer between PC redirect logic and IDU.
// Ports: IDU head (if_*), redirect inputs, icache psel/pready port, fifo_count_o.
module ysyx_23060025_ifu_prefetch
    import ysyx_23060025_ifu_prefetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(PC_RESET_VAL)
) (
    input  logic                          clock,
    input  logic                          rstn,
    input  logic                          idu_ready_i,
    output logic                          if_valid_o,
    output logic [DATA_WIDTH-1:0]         if_inst_o,
    output logic [ADDR_WIDTH-1:0]         if_pc_o,
    input  logic                          branch_flag_i,
    input  logic                          branch_request_i,
    input  logic [ADDR_WIDTH-1:0]         branch_target_i,
    input  logic                          jmp_flag_i,
    input  logic [ADDR_WIDTH-1:0]         jmp_target_i,
    input  logic                          csr_jmp_i,
    input  logic [ADDR_WIDTH-1:0]         csr_pc_i,
    input  logic                          ebreak_flag_i,
    output logic                          out_psel,
    output logic [ADDR_WIDTH-1:0]         out_paddr,
    input  logic                          out_pready,
    input  logic [DATA_WIDTH-1:0]         out_prdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                  psel_q, psel_d;

    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  redir_en;
    logic                  take_redir;
    logic                  accept;
    logic                  hold;
    logic                  stale;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count_d;

    always_comb begin
        redirect    = (branch_flag_i & branch_request_i) | jmp_flag_i | csr_jmp_i;
        redirect_pc = csr_pc_i;
        if (branch_flag_i & branch_request_i) redirect_pc = branch_target_i;
        else if (jmp_flag_i)                  redirect_pc = jmp_target_i;

        accept = psel_q & out_pready;
        hold   = psel_q & ~out_pready;
        pop    = if_valid_o & idu_ready_i;

        // An ebreak seen in FETCH wins over a same-cycle redirect.
        redir_en = 1'b0;
        state_d  = state_q;
        unique case (state_q)
            IFU_ST_FETCH: begin
                redir_en = ~ebreak_flag_i;
                if (ebreak_flag_i)
                    state_d = hold ? IFU_ST_HALT_PEND : IFU_ST_HALT;
                else if (redirect && hold)
                    state_d = IFU_ST_DRAIN;
            end
            IFU_ST_DRAIN: begin
                redir_en = 1'b1;
                if (out_pready) state_d = IFU_ST_FETCH;
            end
            IFU_ST_HALT_PEND: begin
                redir_en = 1'b1;
                if (out_pready) state_d = IFU_ST_HALT;
            end
            IFU_ST_HALT: begin
                redir_en = 1'b0;
            end
        endcase

        take_redir = redirect & redir_en;
        stale      = (state_q == IFU_ST_DRAIN) | take_redir;
        push       = accept & ~stale;
        count_d    = take_redir ? '0
                   : fifo_count_o + CW'(push) - CW'(pop);

        fetch_pc_d = fetch_pc_q;
        if (push)       fetch_pc_d = fetch_pc_q + PC_INC;
        if (take_redir) fetch_pc_d = redirect_pc;

        // In-flight requests are held stable; otherwise issue when room remains.
        if (hold) begin
            psel_d  = 1'b1;
            paddr_d = paddr_q;
        end else begin
            psel_d  = (state_d == IFU_ST_FETCH) && (count_d < DEPTH_C);
            paddr_d = fetch_pc_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q    <= IFU_ST_FETCH;
            fetch_pc_q <= RESET_PC;
            paddr_q    <= RESET_PC;
            psel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            paddr_q    <= paddr_d;
            psel_q     <= psel_d;
        end
    end

    ysyx_23060025_fetch_fifo #(
        .WIDTH (ADDR_WIDTH + DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rstn_i  (rstn),
        .flush_i (take_redir),
        .push_i  (push),
        .data_i  ({paddr_q, out_prdata}),
        .pop_i   (pop),
        .head_o  ({if_pc_o, if_inst_o}),
        .count_o (fifo_count_o)
    );

    assign if_valid_o = (fifo_count_o != '0);
    assign out_psel   = psel_q;
    assign out_paddr  = paddr_q;

`ifdef YSYX_IFU_PERF
    logic [63:0] perf_fetch_q;
    always_ff @(posedge clock) begin
        if (!rstn)    perf_fetch_q <= '0;
        else if (pop) perf_fetch_q <= perf_fetch_q + 64'd1;
    end
`endif

endmodule

// File: tb/tb_ysyx_23060025_ifu_prefetch.sv
// Bench for the prefetching IFU: directed scenarios plus a randomized run
// against a queue-based model of the fetch stream.
module tb_ysyx_23060025_ifu_prefetch;

    localparam logic [31:0] RST = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        rstn;
    logic        idu_ready_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
    logic        branch_flag_i;
    logic        branch_request_i;
    logic [31:0] branch_target_i;
    logic        jmp_flag_i;
    logic [31:0] jmp_target_i;
    logic        csr_jmp_i;
    logic [31:0] csr_pc_i;
    logic        ebreak_flag_i;
    logic        out_psel;
    logic [31:0] out_paddr;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic [2:0]  fifo_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    assign out_prdata = memf(out_paddr);

    ysyx_23060025_ifu_prefetch #(.FIFO_DEPTH(4)) dut (
        .clock            (clock),
        .rstn             (rstn),
        .idu_ready_i      (idu_ready_i),
        .if_valid_o       (if_valid_o),
        .if_inst_o        (if_inst_o),
        .if_pc_o          (if_pc_o),
        .branch_flag_i    (branch_flag_i),
        .branch_request_i (branch_request_i),
        .branch_target_i  (branch_target_i),
        .jmp_flag_i       (jmp_flag_i),
        .jmp_target_i     (jmp_target_i),
        .csr_jmp_i        (csr_jmp_i),
        .csr_pc_i         (csr_pc_i),
        .ebreak_flag_i    (ebreak_flag_i),
        .out_psel         (out_psel),
        .out_paddr        (out_paddr),
        .out_pready       (out_pready),
        .out_prdata       (out_prdata),
        .fifo_count_o     (fifo_count_o)
    );

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        idu_ready_i      = 1'b0;
        branch_flag_i    = 1'b0;
        branch_request_i = 1'b0;
        branch_target_i  = '0;
        jmp_flag_i       = 1'b0;
        jmp_target_i     = '0;
        csr_jmp_i        = 1'b0;
        csr_pc_i         = '0;
        ebreak_flag_i    = 1'b0;
        out_pready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rstn = 1'b0;
        cycle();
        cycle();
        rstn = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        cycle();
        cycle();
        n_cmp++;
        if (out_psel !== 1'b0) begin
            n_fail++; $display("FAIL reset_psel got %b exp 0", out_psel);
        end
        n_cmp++;
        if (out_paddr !== RST) begin
            n_fail++; $display("FAIL reset_paddr got %h exp %h", out_paddr, RST);
        end
        n_cmp++;
        if (if_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b exp 0", if_valid_o);
        end
        n_cmp++;
        if (if_inst_o !== 32'h0 || if_pc_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_head got %h/%h exp 0/0", if_pc_o, if_inst_o);
        end
        n_cmp++;
        if (fifo_count_o !== 3'd0) begin
            n_fail++; $display("FAIL reset_count got %0d exp 0", fifo_count_o);
        end
        rstn = 1'b1;
        cycle();
        n_cmp++;
        if (out_psel !== 1'b1 || out_paddr !== RST) begin
            n_fail++; $display("FAIL first_req got %b/%h exp 1/%h", out_psel, out_paddr, RST);
        end
    endtask

    task automatic test_stream();
        do_reset();
        idu_ready_i = 1'b1;
        out_pready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_psel !== 1'b1 || out_paddr !== RST + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL stream_req%0d got %b/%h exp 1/%h", i, out_psel, out_paddr, RST + 32'(4 * i));
            end
            n_cmp++;
            if (if_valid_o !== (i != 0)) begin
                n_fail++; $display("FAIL stream_valid%0d got %b", i, if_valid_o);
            end
            if (i != 0) begin
                n_cmp++;
                if (if_pc_o !== RST + 32'(4 * (i - 1)) || if_inst_o !== memf(RST + 32'(4 * (i - 1)))) begin
                    n_fail++;
                    $display("FAIL stream_head%0d got %h/%h exp %h", i, if_pc_o, if_inst_o, RST + 32'(4 * (i - 1)));
                end
            end
            cycle();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        int acc;
        do_reset();
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            out_pready = out_psel;
            if (out_psel) acc++;
            cycle();
        end
        out_pready = 1'b0;
        n_cmp++;
        if (acc != 4) begin
            n_fail++; $display("FAIL full_accepts got %0d exp 4", acc);
        end
        n_cmp++;
        if (out_psel !== 1'b0 || fifo_count_o !== 3'd4) begin
            n_fail++; $display("FAIL full_state got psel %b cnt %0d exp 0/4", out_psel, fifo_count_o);
        end
        n_cmp++;
        if (if_valid_o !== 1'b1 || if_pc_o !== RST) begin
            n_fail++; $display("FAIL full_head got %b/%h exp 1/%h", if_valid_o, if_pc_o, RST);
        end
        idu_ready_i = 1'b1;
        cycle();
        idu_ready_i = 1'b0;
        n_cmp++;
        if (fifo_count_o !== 3'd3 || if_pc_o !== RST + 32'd4) begin
            n_fail++; $display("FAIL full_pop got cnt %0d pc %h exp 3/%h", fifo_count_o, if_pc_o, RST + 32'd4);
        end
        n_cmp++;
        if (out_psel !== 1'b1 || out_paddr !== RST + 32'd16) begin
            n_fail++; $display("FAIL full_refill got %b/%h exp 1/%h", out_psel, out_paddr, RST + 32'd16);
        end
    endtask

    task automatic test_drain_jmp();
        do_reset();
        idu_ready_i = 1'b1;
        out_pready  = 1'b1;
        repeat (4) cycle();
        out_pready   = 1'b0;
        n_cmp++;
        if (out_psel !== 1'b1 || out_paddr !== RST + 32'h10) begin
            n_fail++; $display("FAIL drain_setup got %b/%h exp 1/%h", out_psel, out_paddr, RST + 32'h10);
        end
        jmp_flag_i   = 1'b1;
        jmp_target_i = RST + 32'h100;
        cycle();
        jmp_flag_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (out_psel !== 1'b1 || out_paddr !== RST + 32'h10) begin
                n_fail++; $display("FAIL drain_hold%0d got %b/%h exp 1/%h", i, out_psel, out_paddr, RST + 32'h10);
            end
            n_cmp++;
            if (fifo_count_o !== 3'd0 || if_valid_o !== 1'b0) begin
                n_fail++; $display("FAIL drain_empty%0d got cnt %0d exp 0", i, fifo_count_o);
            end
            if (i == 1) out_pready = 1'b1;
            cycle();
        end
        n_cmp++;
        if (fifo_count_o !== 3'd0 || out_psel !== 1'b1 || out_paddr !== RST + 32'h100) begin
            n_fail++;
            $display("FAIL drain_retarget got cnt %0d %b/%h exp 0 1/%h", fifo_count_o, out_psel, out_paddr, RST + 32'h100);
        end
        cycle();
        n_cmp++;
        if (if_valid_o !== 1'b1 || if_pc_o !== RST + 32'h100 || if_inst_o !== memf(RST + 32'h100)) begin
            n_fail++; $display("FAIL drain_first got %b %h/%h exp 1 %h", if_valid_o, if_pc_o, if_inst_o, RST + 32'h100);
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        out_pready       = 1'b1;
        branch_flag_i    = 1'b1;
        branch_request_i = 1'b1;
        branch_target_i  = RST + 32'h200;
        jmp_flag_i       = 1'b1;
        jmp_target_i     = RST + 32'h300;
        csr_jmp_i        = 1'b1;
        csr_pc_i         = RST + 32'h400;
        cycle();
        n_cmp++;
        if (fifo_count_o !== 3'd0 || out_paddr !== RST + 32'h200) begin
            n_fail++; $display("FAIL prio_branch got cnt %0d %h exp 0 %h", fifo_count_o, out_paddr, RST + 32'h200);
        end
        branch_request_i = 1'b0;
        cycle();
        n_cmp++;
        if (fifo_count_o !== 3'd0 || out_paddr !== RST + 32'h300) begin
            n_fail++; $display("FAIL prio_jmp got cnt %0d %h exp 0 %h", fifo_count_o, out_paddr, RST + 32'h300);
        end
        branch_flag_i = 1'b0;
        jmp_flag_i    = 1'b0;
        cycle();
        n_cmp++;
        if (fifo_count_o !== 3'd0 || out_paddr !== RST + 32'h400) begin
            n_fail++; $display("FAIL prio_csr got cnt %0d %h exp 0 %h", fifo_count_o, out_paddr, RST + 32'h400);
        end
        csr_jmp_i = 1'b0;
        cycle();
        n_cmp++;
        if (fifo_count_o !== 3'd1 || if_pc_o !== RST + 32'h400 || out_paddr !== RST + 32'h404) begin
            n_fail++; $display("FAIL prio_after got cnt %0d %h %h", fifo_count_o, if_pc_o, out_paddr);
        end
        idle_inputs();
    endtask

    task automatic test_ebreak();
        do_reset();
        ebreak_flag_i = 1'b1;
        cycle();
        ebreak_flag_i = 1'b0;
        n_cmp++;
        if (out_psel !== 1'b1 || out_paddr !== RST) begin
            n_fail++; $display("FAIL ebreak_hold got %b/%h exp 1/%h", out_psel, out_paddr, RST);
        end
        out_pready = 1'b1;
        cycle();
        out_pready = 1'b0;
        n_cmp++;
        if (out_psel !== 1'b0 || fifo_count_o !== 3'd1 || if_pc_o !== RST) begin
            n_fail++; $display("FAIL ebreak_buf got %b cnt %0d pc %h", out_psel, fifo_count_o, if_pc_o);
        end
        jmp_flag_i   = 1'b1;
        jmp_target_i = RST + 32'h100;
        cycle();
        jmp_flag_i = 1'b0;
        n_cmp++;
        if (out_psel !== 1'b0 || fifo_count_o !== 3'd1) begin
            n_fail++; $display("FAIL ebreak_redir got %b cnt %0d exp 0/1", out_psel, fifo_count_o);
        end
        idu_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++;
            if (out_psel !== 1'b0 || fifo_count_o !== 3'd0) begin
                n_fail++; $display("FAIL ebreak_halt%0d got %b cnt %0d exp 0/0", i, out_psel, fifo_count_o);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_pready = 1'b1;
        repeat (3) cycle();
        out_pready = 1'b0;
        cycle();
        n_cmp++;
        if (fifo_count_o !== 3'd3 || out_psel !== 1'b1 || out_paddr !== RST + 32'hc) begin
            n_fail++; $display("FAIL mid_setup got cnt %0d %b/%h", fifo_count_o, out_psel, out_paddr);
        end
        rstn       = 1'b0;
        out_pready = 1'b1;
        cycle();
        n_cmp++;
        if (out_psel !== 1'b0 || out_paddr !== RST || fifo_count_o !== 3'd0) begin
            n_fail++; $display("FAIL mid_reset got %b/%h cnt %0d", out_psel, out_paddr, fifo_count_o);
        end
        n_cmp++;
        if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin
            n_fail++; $display("FAIL mid_head got %b %h/%h exp 0", if_valid_o, if_pc_o, if_inst_o);
        end
        rstn       = 1'b1;
        out_pready = 1'b0;
        cycle();
        n_cmp++;
        if (out_psel !== 1'b1 || out_paddr !== RST || fifo_count_o !== 3'd0) begin
            n_fail++; $display("FAIL mid_restart got %b/%h cnt %0d", out_psel, out_paddr, fifo_count_o);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [31:0] q_pc[$];
        logic [31:0] q_in[$];
        logic        exp_psel;
        logic [31:0] exp_paddr;
        logic [31:0] mpc;
        logic [31:0] tgt;
        logic        stale;
        logic        redir;
        logic        bad;
        do_reset();
        exp_psel  = 1'b1;
        exp_paddr = RST;
        mpc       = RST;
        stale     = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            bad = (out_psel !== exp_psel) || (exp_psel && out_paddr !== exp_paddr);
            n_cmp++;
            if (bad) begin
                n_fail++;
                $display("FAIL rnd_req c%0d got %b/%h exp %b/%h", c, out_psel, out_paddr, exp_psel, exp_paddr);
            end
            bad = (fifo_count_o !== 3'(q_pc.size())) || (if_valid_o !== (q_pc.size() != 0));
            if (!bad && q_pc.size() != 0)
                bad = (if_pc_o !== q_pc[0]) || (if_inst_o !== q_in[0]);
            n_cmp++;
            if (bad) begin
                n_fail++;
                $display("FAIL rnd_head c%0d got cnt %0d %h/%h exp cnt %0d", c, fifo_count_o, if_pc_o, if_inst_o, q_pc.size());
            end
            idu_ready_i      = ($urandom % 4) != 0;
            out_pready       = out_psel & (($urandom % 3) != 0);
            branch_target_i  = RST + 32'($urandom_range(0, 255) * 4);
            jmp_target_i     = RST + 32'($urandom_range(0, 255) * 4);
            csr_pc_i         = RST + 32'($urandom_range(0, 255) * 4);
            branch_flag_i    = 1'b0;
            branch_request_i = 1'b0;
            jmp_flag_i       = 1'b0;
            csr_jmp_i        = 1'b0;
            if ($urandom % 12 == 0) begin
                branch_flag_i    = $urandom % 2 == 0;
                branch_request_i = $urandom % 2 == 0;
                jmp_flag_i       = $urandom % 2 == 0;
                csr_jmp_i        = $urandom % 2 == 0;
            end
            redir = (branch_flag_i && branch_request_i) || jmp_flag_i || csr_jmp_i;
            if (branch_flag_i && branch_request_i) tgt = branch_target_i;
            else if (jmp_flag_i)                   tgt = jmp_target_i;
            else                                   tgt = csr_pc_i;
            if (q_pc.size() != 0 && idu_ready_i) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (exp_psel && out_pready) begin
                if (!stale && !redir) begin
                    q_pc.push_back(exp_paddr);
                    q_in.push_back(memf(exp_paddr));
                    mpc = exp_paddr + 32'd4;
                end
                stale = 1'b0;
            end
            if (redir) begin
                q_pc.delete();
                q_in.delete();
                mpc = tgt;
                if (exp_psel && !out_pready) stale = 1'b1;
            end
            if (!(exp_psel && !out_pready)) begin
                exp_psel  = q_pc.size() < 4;
                exp_paddr = mpc;
            end
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_full();
        test_drain_jmp();
        test_priority();
        test_ebreak();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
